// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - boot loader: streams a program image into memory, writes the reset vector, releases the CPU
module mem_loader #(
    parameter int          ADDR_WIDTH  = 16,
    parameter int          DATA_WIDTH  = 8,
    parameter logic [15:0] VEC_ADDR    = 16'hFFFC,
    parameter bit          WRITE_VEC   = 1'b1,
    parameter int          HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  cpu_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic                  wrapped
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        VEC_LO = 3'd2,
        VEC_HI = 3'd3,
        HOLD   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                state, state_next;
    state_t                after_start, after_payload;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   remaining;
    logic [7:0]            hold_cnt;
    logic [15:0]           base_ext;
    logic                  start_ok;
    logic                  accept;
    logic                  hold_end;

    // Vector bytes are always 16-bit 6502 little-endian, zero-extended for narrow address spaces
    assign base_ext = 16'(base_q);

    assign start_ok = start && (state == IDLE || state == DONE);
    assign accept   = in_valid && (state == LOAD);
    assign hold_end = (hold_cnt == 8'(HOLD_CYCLES - 1));

    assign after_payload = WRITE_VEC ? VEC_LO : HOLD;
    assign after_start   = (length != '0) ? LOAD : after_payload;

    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        cpu_reset_n = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = after_start;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (accept && remaining == (ADDR_WIDTH+1)'(1)) state_next = after_payload;
            end
            VEC_LO: state_next = VEC_HI;
            VEC_HI: state_next = HOLD;
            HOLD: begin
                if (hold_end) state_next = DONE;
            end
            DONE: begin
                busy        = 1'b0;
                done        = 1'b1;
                cpu_reset_n = 1'b1;
                if (start) state_next = after_start;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            base_q    <= '0;
            remaining <= '0;
            hold_cnt  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            wrapped   <= 1'b0;
        end else begin
            state  <= state_next;
            mem_we <= 1'b0;
            hold_cnt <= (state == HOLD) ? hold_cnt + 8'd1 : 8'd0;

            if (start_ok) begin
                ptr       <= base_addr;
                base_q    <= base_addr;
                remaining <= length;
                wrapped   <= 1'b0;
            end

            // Memory port lags the accepting edge by one cycle, so writes stay registered
            case (state)
                LOAD: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr;
                        mem_din   <= in_data;
                        ptr       <= ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (&ptr) wrapped <= 1'b1;
                    end
                end
                VEC_LO: begin
                    mem_we   <= 1'b1;
                    mem_addr <= ADDR_WIDTH'(VEC_ADDR);
                    mem_din  <= DATA_WIDTH'(base_ext[7:0]);
                end
                VEC_HI: begin
                    mem_we   <= 1'b1;
                    mem_addr <= ADDR_WIDTH'(VEC_ADDR + 16'd1);
                    mem_din  <= DATA_WIDTH'(base_ext[15:8]);
                end
                default: ;
            endcase
        end
    end

endmodule
